// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings and ALU control codes for the single-cycle MIPS slice
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// rtl/mips_alu_core.sv - 32-bit ALU: and/or/add/sub/signed slt with zero flag
module mips_alu_core
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_e   alucontrol,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = a + b;
    unique case (alucontrol)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_sc_core.sv
// rtl/mips_sc_core.sv - single-cycle MIPS core slice: PC, decode, ALU, next-PC logic
// Optional: define MIPS_JUMP_EN to decode the j instruction.
module mips_sc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter int          BRANCH_IMM_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] reg_rd1,
  input  logic [31:0] reg_rd2,
  input  logic [31:0] mem_rd,
  output logic [31:0] pc,
  output logic [4:0]  reg_a1,
  output logic [4:0]  reg_a2,
  output logic [4:0]  reg_a3,
  output logic        reg_we3,
  output logic [31:0] reg_wd3,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        zero
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump;
  alu_ctrl_e   alucontrol;
  logic [31:0] imm_ext, src_b, alu_result;
  logic [31:0] pc_plus4, br_tgt, pc_next;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    regwrite   = 1'b0;
    regdst     = 1'b0;
    alusrc     = 1'b0;
    branch     = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    jump       = 1'b0;
    alucontrol = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        unique case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          // Unrecognised funct must not clobber the register file.
          default: regwrite = 1'b0;
        endcase
      end
      OP_LW: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch     = 1'b1;
        alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
`ifdef MIPS_JUMP_EN
      OP_J: jump = 1'b1;
`endif
      default: ;
    endcase
  end

  assign imm_ext = sext16(instr[15:0]);
  assign src_b   = alusrc ? imm_ext : reg_rd2;

  mips_alu_core u_alu (
    .a          (reg_rd1),
    .b          (src_b),
    .alucontrol (alucontrol),
    .result     (alu_result),
    .zero       (zero)
  );

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + (imm_ext << BRANCH_IMM_SHIFT);

`ifdef MIPS_JUMP_EN
  assign pc_next = jump ? {pc_plus4[31:28], instr[25:0], 2'b00}
                 : (branch & zero) ? br_tgt : pc_plus4;
`else
  assign pc_next = (branch & zero & ~jump) ? br_tgt : pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  assign reg_a1  = instr[25:21];
  assign reg_a2  = instr[20:16];
  assign reg_a3  = regdst ? instr[15:11] : instr[20:16];
  assign reg_we3 = regwrite & rst_n;
  assign reg_wd3 = memtoreg ? mem_rd : alu_result;
  assign mem_a   = alu_result;
  assign mem_wd  = reg_rd2;
  assign mem_we  = memwrite & rst_n;

endmodule

// File: tb/tb_mips_sc_core.sv
// tb/tb_mips_sc_core.sv - self-checking bench for mips_sc_core (vectors, corner sequences, random vs model)
module tb_mips_sc_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, reg_rd1, reg_rd2, mem_rd;
  logic [31:0] pc, reg_wd3, mem_a, mem_wd;
  logic [4:0]  reg_a1, reg_a2, reg_a3;
  logic        reg_we3, mem_we, zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mips_sc_core dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .reg_rd1(reg_rd1), .reg_rd2(reg_rd2),
    .mem_rd(mem_rd), .pc(pc), .reg_a1(reg_a1), .reg_a2(reg_a2), .reg_a3(reg_a3),
    .reg_we3(reg_we3), .reg_wd3(reg_wd3), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_we(mem_we), .zero(zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr, rd1, rd2, mrd;
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd3, mem_a;
    logic        mem_we, zero;
  } vec_t;

  typedef struct {
    logic [4:0]  a3;
    logic        we3, mem_we, zero;
    logic [31:0] alu, wd3, npc;
  } exp_t;

  // Reference model: instruction semantics computed directly from the mnemonic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rd1,
                                 input logic [31:0] rd2, input logic [31:0] mrd,
                                 input logic [31:0] cur_pc);
    exp_t e;
    logic [31:0] simm, p4;
    simm     = {{16{ins[15]}}, ins[15:0]};
    p4       = cur_pc + 32'd4;
    e.a3     = ins[20:16];
    e.we3    = 1'b0;
    e.mem_we = 1'b0;
    e.alu    = rd1 + rd2;
    e.npc    = p4;
    case (ins[31:26])
      6'b000000: begin
        e.a3 = ins[15:11];
        case (ins[5:0])
          6'b100000: begin e.alu = rd1 + rd2; e.we3 = 1'b1; end
          6'b100010: begin e.alu = rd1 - rd2; e.we3 = 1'b1; end
          6'b100100: begin e.alu = rd1 & rd2; e.we3 = 1'b1; end
          6'b100101: begin e.alu = rd1 | rd2; e.we3 = 1'b1; end
          6'b101010: begin e.alu = ($signed(rd1) < $signed(rd2)) ? 32'd1 : 32'd0; e.we3 = 1'b1; end
          default:   e.alu = rd1 + rd2;
        endcase
      end
      6'b100011: begin e.alu = rd1 + simm; e.we3 = 1'b1; end
      6'b101011: begin e.alu = rd1 + simm; e.mem_we = 1'b1; end
      6'b000100: begin
        e.alu = rd1 - rd2;
        if (rd1 == rd2) e.npc = p4 + simm;
      end
      6'b001000: begin e.alu = rd1 + simm; e.we3 = 1'b1; end
`ifdef MIPS_JUMP_EN
      6'b000010: e.npc = {p4[31:28], ins[25:0], 2'b00};
`endif
      default: ;
    endcase
    e.wd3  = (ins[31:26] == 6'b100011) ? mrd : e.alu;
    e.zero = (e.alu == 32'd0);
    return e;
  endfunction

  task automatic reset_to_pc8();
    @(negedge clk);
    rst_n = 1'b0;
    instr = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[10];
  exp_t e;
  logic [31:0] mpc;
  logic [31:0] jexp;

  initial begin
    vecs[0] = '{32'h00221820, 32'd5, 32'd7, 32'h0, 5'd3, 1'b1, 32'd12, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{32'h00221822, 32'd9, 32'd9, 32'h0, 5'd3, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1};
    vecs[2] = '{32'h0022182A, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd3, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{32'h0022182A, 32'd1, 32'hFFFFFFFF, 32'h0, 5'd3, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1};
    vecs[4] = '{32'h8C220004, 32'h100, 32'd3, 32'hABCD, 5'd2, 1'b1, 32'hABCD, 32'h104, 1'b0, 1'b0};
    vecs[5] = '{32'hAC220004, 32'h100, 32'd3, 32'hABCD, 5'd2, 1'b0, 32'h104, 32'h104, 1'b1, 1'b0};
    vecs[6] = '{32'h00221824, 32'hF0F0, 32'hFF00, 32'h0, 5'd3, 1'b1, 32'hF000, 32'hF000, 1'b0, 1'b0};
    vecs[7] = '{32'h00221825, 32'hF0F0, 32'h0F00, 32'h0, 5'd3, 1'b1, 32'hFFF0, 32'hFFF0, 1'b0, 1'b0};
    vecs[8] = '{32'h00221821, 32'd2, 32'd3, 32'h0, 5'd3, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0};
    vecs[9] = '{32'h2022FFFF, 32'd1, 32'd0, 32'h0, 5'd2, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1};

    rst_n = 1'b0; instr = 32'h00221820; reg_rd1 = 32'd5; reg_rd2 = 32'd7; mem_rd = 32'h0;
    #3;
    chk("reset_pc", pc, 32'h0);
    chk("reset_we3", {31'd0, reg_we3}, 32'd0);
    instr = 32'hAC220004;
    #1;
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    instr = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pc_after_1", pc, 32'd4);
    @(posedge clk); #1;
    chk("pc_after_2", pc, 32'd8);

    @(negedge clk);
    instr = 32'h10220010; reg_rd1 = 32'd3; reg_rd2 = 32'd3;
    @(posedge clk); #1;
    chk("beq_taken_fwd", pc, 32'd28);
    reset_to_pc8();
    instr = 32'h10220010; reg_rd1 = 32'd3; reg_rd2 = 32'd4;
    @(posedge clk); #1;
    chk("beq_not_taken", pc, 32'd12);
    reset_to_pc8();
    instr = 32'h1022FFF8; reg_rd1 = 32'd6; reg_rd2 = 32'd6;
    @(posedge clk); #1;
    chk("beq_taken_back", pc, 32'd4);

    @(negedge clk);
    rst_n = 1'b0; instr = 32'h08000010; reg_rd1 = 32'd1; reg_rd2 = 32'd2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("j_we3", {31'd0, reg_we3}, 32'd0);
    chk("j_mem_we", {31'd0, mem_we}, 32'd0);
`ifdef MIPS_JUMP_EN
    jexp = 32'h40;
`else
    jexp = 32'h4;
`endif
    @(posedge clk); #1;
    chk("j_next_pc", pc, jexp);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr = vecs[i].instr; reg_rd1 = vecs[i].rd1; reg_rd2 = vecs[i].rd2; mem_rd = vecs[i].mrd;
      #1;
      chk($sformatf("vec%0d_a3", i), {27'd0, reg_a3}, {27'd0, vecs[i].a3});
      chk($sformatf("vec%0d_we3", i), {31'd0, reg_we3}, {31'd0, vecs[i].we3});
      chk($sformatf("vec%0d_wd3", i), reg_wd3, vecs[i].wd3);
      chk($sformatf("vec%0d_mem_a", i), mem_a, vecs[i].mem_a);
      chk($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mem_we});
      chk($sformatf("vec%0d_mem_wd", i), mem_wd, vecs[i].rd2);
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
    end

    @(negedge clk);
    rst_n = 1'b0; instr = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 32'h0;
    for (int i = 0; i < 200; i++) begin
      logic [5:0] fns[6];
      int kind;
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      kind = $urandom_range(0, 7);
      instr = $urandom;
      reg_rd1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
      reg_rd2 = ($urandom_range(0, 1) == 0) ? reg_rd1 : $urandom;
      mem_rd = $urandom;
      case (kind)
        0, 1: begin
          instr[31:26] = 6'b000000;
          instr[5:0] = fns[$urandom_range(0, 5)];
          if (instr[5:0] == 6'b000000) instr[5:0] = 6'($urandom_range(0, 31));
        end
        2: instr[31:26] = 6'b100011;
        3: instr[31:26] = 6'b101011;
        4: instr[31:26] = 6'b000100;
        5: instr[31:26] = 6'b001000;
        6: instr[31:26] = 6'b000010;
        default: ;
      endcase
      #1;
      e = model(instr, reg_rd1, reg_rd2, mem_rd, mpc);
      chk("rnd_a1", {27'd0, reg_a1}, {27'd0, instr[25:21]});
      chk("rnd_a2", {27'd0, reg_a2}, {27'd0, instr[20:16]});
      chk("rnd_a3", {27'd0, reg_a3}, {27'd0, e.a3});
      chk("rnd_we3", {31'd0, reg_we3}, {31'd0, e.we3});
      chk("rnd_wd3", reg_wd3, e.wd3);
      chk("rnd_mem_a", mem_a, e.alu);
      chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, e.mem_we});
      chk("rnd_zero", {31'd0, zero}, {31'd0, e.zero});
      @(posedge clk); #1;
      chk("rnd_pc", pc, e.npc);
      mpc = e.npc;
      @(negedge clk);
    end

    instr = 32'h00221820; reg_rd1 = 32'd1; reg_rd2 = 32'd1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_pc", pc, 32'h0);
    chk("midreset_we3", {31'd0, reg_we3}, 32'd0);
    @(posedge clk); #1;
    chk("midreset_hold", pc, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
